ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 117 +++++++++++
 tb/tb_ram_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Clears the whole RAM to zero after reset before serving requests.
module ram_port_arbiter #(
    parameter int SIZE  = 5,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_we,
    input  logic [SIZE-1:0]  req0_adr,
    input  logic [WIDTH-1:0] req0_dat,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_we,
    input  logic [SIZE-1:0]  req1_adr,
    input  logic [WIDTH-1:0] req1_dat,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_dat,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_dat,
    output logic             ram_sel,
    output logic             ram_we,
    output logic [SIZE-1:0]  ram_adr,
    output logic [WIDTH-1:0] ram_dat_i,
    input  logic [WIDTH-1:0] ram_dat_o,
    output logic             init_done
);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            rsp0_valid_q, rsp0_valid_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic            init_done_q, init_done_d;
    logic            grant0, grant1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        init_done_d  = init_done_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        grant0       = 1'b0;
        grant1       = 1'b0;
        ram_sel      = 1'b0;
        ram_we       = 1'b0;
        ram_adr      = '0;
        ram_dat_i    = '0;

        if (rst) begin
            ram_sel = 1'b1;
            ram_we  = 1'b1;
        end else if (state_q == INIT) begin
            ram_sel = 1'b1;
            ram_we  = 1'b1;
            ram_adr = cnt_q;
            // Saturate on the last address so the clear never starts a second pass.
            if (cnt_q == {SIZE{1'b1}}) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // last_q=1 means req1 won last time, so req0 has priority on contention.
            grant0 = req0_valid & (~req1_valid | last_q);
            grant1 = req1_valid & (~req0_valid | ~last_q);
            if (grant0) begin
                ram_sel      = 1'b1;
                ram_we       = req0_we;
                ram_adr      = req0_adr;
                ram_dat_i    = req0_dat;
                last_d       = 1'b0;
                rsp0_valid_d = ~req0_we;
            end else if (grant1) begin
                ram_sel      = 1'b1;
                ram_we       = req1_we;
                ram_adr      = req1_adr;
                ram_dat_i    = req1_dat;
                last_d       = 1'b1;
                rsp1_valid_d = ~req1_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            last_q       <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_dat   = ram_dat_o;
    assign rsp1_dat   = ram_dat_o;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-read RAM attached.
module tb_ram_port_arbiter;

    localparam int SIZE  = 5;
    localparam int WIDTH = 64;
    localparam int DEPTH = 1 << SIZE;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_we;
    logic [SIZE-1:0]  req0_adr;
    logic [WIDTH-1:0] req0_dat;
    logic             req1_valid, req1_ready, req1_we;
    logic [SIZE-1:0]  req1_adr;
    logic [WIDTH-1:0] req1_dat;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp0_dat, rsp1_dat;
    logic             ram_sel, ram_we;
    logic [SIZE-1:0]  ram_adr;
    logic [WIDTH-1:0] ram_dat_i;
    logic [WIDTH-1:0] ram_dat_o;
    logic             init_done;

    logic [WIDTH-1:0] mem [DEPTH];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_adr(req0_adr), .req0_dat(req0_dat),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_adr(req1_adr), .req1_dat(req1_dat),
        .rsp0_valid(rsp0_valid), .rsp0_dat(rsp0_dat),
        .rsp1_valid(rsp1_valid), .rsp1_dat(rsp1_dat),
        .ram_sel(ram_sel), .ram_we(ram_we), .ram_adr(ram_adr),
        .ram_dat_i(ram_dat_i), .ram_dat_o(ram_dat_o), .init_done(init_done)
    );

    // External single-port RAM: write on the edge, read data registered.
    always @(posedge clk) begin
        if (ram_sel) begin
            if (ram_we) mem[ram_adr] <= ram_dat_i;
            else        ram_dat_o    <= mem[ram_adr];
        end
    end

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; req0_adr = 5'd9; req1_adr = 5'd9;
        #1;
        vecs++; if (init_done !== 1'b0) begin errs++; $display("[TB] FAIL rst_init_done got %b want 0", init_done); end
        vecs++; if (rsp0_valid !== 1'b0) begin errs++; $display("[TB] FAIL rst_rsp0_valid got %b want 0", rsp0_valid); end
        vecs++; if (rsp1_valid !== 1'b0) begin errs++; $display("[TB] FAIL rst_rsp1_valid got %b want 0", rsp1_valid); end
        vecs++; if (req0_ready !== 1'b0) begin errs++; $display("[TB] FAIL rst_ready0 got %b want 0", req0_ready); end
        vecs++; if (req1_ready !== 1'b0) begin errs++; $display("[TB] FAIL rst_ready1 got %b want 0", req1_ready); end
        vecs++; if (ram_sel !== 1'b1) begin errs++; $display("[TB] FAIL rst_ram_sel got %b want 1", ram_sel); end
        vecs++; if (ram_we !== 1'b1) begin errs++; $display("[TB] FAIL rst_ram_we got %b want 1", ram_we); end
        vecs++; if (ram_adr !== 5'd0) begin errs++; $display("[TB] FAIL rst_ram_adr got %0d want 0", ram_adr); end
        vecs++; if (ram_dat_i !== 64'd0) begin errs++; $display("[TB] FAIL rst_ram_dat_i got %h want 0", ram_dat_i); end
        req0_valid = 1'b0; req1_valid = 1'b0; req0_adr = '0; req1_adr = '0;
        rst = 1'b0;
    endtask

    task automatic test_init_clear();
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            vecs++; if (ram_adr !== 5'(i)) begin errs++; $display("[TB] FAIL clr_adr[%0d] got %0d want %0d", i, ram_adr, i); end
            vecs++; if ({ram_sel, ram_we} !== 2'b11) begin errs++; $display("[TB] FAIL clr_sel_we[%0d] got %b want 11", i, {ram_sel, ram_we}); end
            vecs++; if (ram_dat_i !== 64'd0) begin errs++; $display("[TB] FAIL clr_dat[%0d] got %h want 0", i, ram_dat_i); end
            vecs++; if (init_done !== 1'b0) begin errs++; $display("[TB] FAIL clr_init_done[%0d] got %b want 0", i, init_done); end
            vecs++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errs++; $display("[TB] FAIL clr_rsp[%0d] got %b want 00", i, {rsp0_valid, rsp1_valid}); end
        end
        @(negedge clk); #1;
        vecs++; if (init_done !== 1'b1) begin errs++; $display("[TB] FAIL clr_done got %b want 1", init_done); end
        vecs++; if (ram_sel !== 1'b0) begin errs++; $display("[TB] FAIL clr_run_sel got %b want 0", ram_sel); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b1; req0_adr = 5'd3; req0_dat = 64'hDEAD;
        #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("[TB] FAIL wr_ready got %b want 10", {req0_ready, req1_ready}); end
        vecs++; if ({ram_sel, ram_we} !== 2'b11) begin errs++; $display("[TB] FAIL wr_sel_we got %b want 11", {ram_sel, ram_we}); end
        vecs++; if (ram_adr !== 5'd3) begin errs++; $display("[TB] FAIL wr_adr got %0d want 3", ram_adr); end
        vecs++; if (ram_dat_i !== 64'hDEAD) begin errs++; $display("[TB] FAIL wr_dat got %h want dead", ram_dat_i); end
        @(negedge clk);
        req0_we = 1'b0; req0_dat = '0;
        #1;
        vecs++; if (req0_ready !== 1'b1) begin errs++; $display("[TB] FAIL rd_ready0 got %b want 1", req0_ready); end
        vecs++; if ({ram_sel, ram_we} !== 2'b10) begin errs++; $display("[TB] FAIL rd_sel_we got %b want 10", {ram_sel, ram_we}); end
        vecs++; if (rsp0_valid !== 1'b0) begin errs++; $display("[TB] FAIL wr_no_rsp got %b want 0", rsp0_valid); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        vecs++; if (rsp0_valid !== 1'b1) begin errs++; $display("[TB] FAIL rd_rsp0_valid got %b want 1", rsp0_valid); end
        vecs++; if (rsp0_dat !== 64'hDEAD) begin errs++; $display("[TB] FAIL rd_rsp0_dat got %h want dead", rsp0_dat); end
        vecs++; if (rsp1_valid !== 1'b0) begin errs++; $display("[TB] FAIL rd_rsp1_valid got %b want 0", rsp1_valid); end
        @(negedge clk); #1;
        vecs++; if (rsp0_valid !== 1'b0) begin errs++; $display("[TB] FAIL rd_rsp0_pulse got %b want 0", rsp0_valid); end
    endtask

    task automatic test_req1_write();
        @(negedge clk);
        req1_valid = 1'b1; req1_we = 1'b1; req1_adr = 5'd20; req1_dat = 64'hBEEF;
        #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("[TB] FAIL wr1_ready got %b want 01", {req0_ready, req1_ready}); end
        vecs++; if (ram_adr !== 5'd20) begin errs++; $display("[TB] FAIL wr1_adr got %0d want 20", ram_adr); end
        vecs++; if (ram_dat_i !== 64'hBEEF) begin errs++; $display("[TB] FAIL wr1_dat got %h want beef", ram_dat_i); end
        @(negedge clk);
        req1_valid = 1'b0; req1_we = 1'b0; req1_dat = '0;
        #1;
        vecs++; if (rsp1_valid !== 1'b0) begin errs++; $display("[TB] FAIL wr1_no_rsp got %b want 0", rsp1_valid); end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_adr = 5'd3;
        req1_valid = 1'b1; req1_we = 1'b0; req1_adr = 5'd20;
        #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("[TB] FAIL rr1_ready got %b want 10", {req0_ready, req1_ready}); end
        vecs++; if (ram_adr !== 5'd3) begin errs++; $display("[TB] FAIL rr1_adr got %0d want 3", ram_adr); end
        @(negedge clk); #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("[TB] FAIL rr2_ready got %b want 01", {req0_ready, req1_ready}); end
        vecs++; if (ram_adr !== 5'd20) begin errs++; $display("[TB] FAIL rr2_adr got %0d want 20", ram_adr); end
        vecs++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errs++; $display("[TB] FAIL rr2_rsp got %b want 10", {rsp0_valid, rsp1_valid}); end
        vecs++; if (rsp0_dat !== 64'hDEAD) begin errs++; $display("[TB] FAIL rr2_dat got %h want dead", rsp0_dat); end
        @(negedge clk); #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("[TB] FAIL rr3_ready got %b want 10", {req0_ready, req1_ready}); end
        vecs++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin errs++; $display("[TB] FAIL rr3_rsp got %b want 01", {rsp0_valid, rsp1_valid}); end
        vecs++; if (rsp1_dat !== 64'hBEEF) begin errs++; $display("[TB] FAIL rr3_dat got %h want beef", rsp1_dat); end
        @(negedge clk); #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("[TB] FAIL rr4_ready got %b want 01", {req0_ready, req1_ready}); end
        vecs++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errs++; $display("[TB] FAIL rr4_rsp got %b want 10", {rsp0_valid, rsp1_valid}); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        vecs++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin errs++; $display("[TB] FAIL rr5_rsp got %b want 01", {rsp0_valid, rsp1_valid}); end
        vecs++; if (rsp1_dat !== 64'hBEEF) begin errs++; $display("[TB] FAIL rr5_dat got %h want beef", rsp1_dat); end
    endtask

    task automatic test_single_requester();
        @(negedge clk);
        req1_valid = 1'b1; req1_we = 1'b0; req1_adr = 5'd20;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            vecs++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("[TB] FAIL solo_ready[%0d] got %b want 01", i, {req0_ready, req1_ready}); end
            vecs++; if (rsp1_valid !== (i != 0)) begin errs++; $display("[TB] FAIL solo_rsp1[%0d] got %b want %b", i, rsp1_valid, (i != 0)); end
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        vecs++; if (rsp1_valid !== 1'b1) begin errs++; $display("[TB] FAIL solo_last_rsp got %b want 1", rsp1_valid); end
        @(negedge clk); #1;
        vecs++; if (rsp1_valid !== 1'b0) begin errs++; $display("[TB] FAIL solo_idle_rsp got %b want 0", rsp1_valid); end
    endtask

    task automatic test_idle();
        @(negedge clk);
        req0_valid = 1'b0; req0_we = 1'b1; req0_adr = 5'd5; req0_dat = 64'h123;
        req1_valid = 1'b0; req1_we = 1'b1; req1_adr = 5'd6; req1_dat = 64'h456;
        #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b00) begin errs++; $display("[TB] FAIL idle_ready got %b want 00", {req0_ready, req1_ready}); end
        vecs++; if ({ram_sel, ram_we} !== 2'b00) begin errs++; $display("[TB] FAIL idle_sel_we got %b want 00", {ram_sel, ram_we}); end
        vecs++; if (ram_adr !== 5'd0) begin errs++; $display("[TB] FAIL idle_adr got %0d want 0", ram_adr); end
        vecs++; if (ram_dat_i !== 64'd0) begin errs++; $display("[TB] FAIL idle_dat got %h want 0", ram_dat_i); end
        req0_we = 1'b0; req1_we = 1'b0; req0_dat = '0; req1_dat = '0;
    endtask

    task automatic test_init_requests();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_adr = 5'd0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_adr = 5'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            vecs++; if ({req0_ready, req1_ready} !== 2'b00) begin errs++; $display("[TB] FAIL ireq_ready[%0d] got %b want 00", i, {req0_ready, req1_ready}); end
            vecs++; if (ram_we !== 1'b1) begin errs++; $display("[TB] FAIL ireq_we[%0d] got %b want 1", i, ram_we); end
        end
        @(negedge clk); #1;
        vecs++; if (init_done !== 1'b1) begin errs++; $display("[TB] FAIL ireq_done got %b want 1", init_done); end
        vecs++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("[TB] FAIL ireq_first got %b want 10", {req0_ready, req1_ready}); end
        vecs++; if ({ram_sel, ram_we} !== 2'b10) begin errs++; $display("[TB] FAIL ireq_sel_we got %b want 10", {ram_sel, ram_we}); end
        @(negedge clk); #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("[TB] FAIL ireq_second got %b want 01", {req0_ready, req1_ready}); end
        vecs++; if (rsp0_valid !== 1'b1) begin errs++; $display("[TB] FAIL ireq_rsp0 got %b want 1", rsp0_valid); end
        vecs++; if (rsp0_dat !== 64'd0) begin errs++; $display("[TB] FAIL ireq_dat got %h want 0", rsp0_dat); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        vecs++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin errs++; $display("[TB] FAIL ireq_rsp1 got %b want 01", {rsp0_valid, rsp1_valid}); end
    endtask

    task automatic test_reset_drops_response();
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b1; req0_adr = 5'd7; req0_dat = 64'h77;
        #1;
        vecs++; if (req0_ready !== 1'b1) begin errs++; $display("[TB] FAIL drop_wr_ready got %b want 1", req0_ready); end
        @(negedge clk);
        req0_we = 1'b0; req0_dat = '0; rst = 1'b1;
        #1;
        vecs++; if (ram_adr !== 5'd0) begin errs++; $display("[TB] FAIL drop_rst_adr got %0d want 0", ram_adr); end
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b0;
        #1;
        vecs++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errs++; $display("[TB] FAIL drop_rsp got %b want 00", {rsp0_valid, rsp1_valid}); end
        vecs++; if (init_done !== 1'b0) begin errs++; $display("[TB] FAIL drop_init_done got %b want 0", init_done); end
        vecs++; if (ram_adr !== 5'd0) begin errs++; $display("[TB] FAIL drop_restart_adr got %0d want 0", ram_adr); end
        for (int i = 1; i <= DEPTH; i++) @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_adr = 5'd7;
        #1;
        vecs++; if (init_done !== 1'b1) begin errs++; $display("[TB] FAIL drop_done got %b want 1", init_done); end
        vecs++; if (req0_ready !== 1'b1) begin errs++; $display("[TB] FAIL drop_rd_ready got %b want 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        vecs++; if (rsp0_valid !== 1'b1) begin errs++; $display("[TB] FAIL drop_rd_valid got %b want 1", rsp0_valid); end
        vecs++; if (rsp0_dat !== 64'd0) begin errs++; $display("[TB] FAIL drop_rd_dat got %h want 0", rsp0_dat); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_adr = '0; req0_dat = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_adr = '0; req1_dat = '0;
        test_reset();
        test_init_clear();
        test_write_read();
        test_req1_write();
        test_round_robin();
        test_single_requester();
        test_idle();
        test_init_requests();
        test_reset_drops_response();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
